serial_latch_loader: RTL
========================

# serial_latch_loader

Upstream driver for the gated D latch bank. It accepts a serial bit stream over a valid/ready handshake and assembles a WIDTH-bit word. It then presents the word on the parallel D bus and drives the shared latch enable E with guaranteed setup and hold margins. The downstream level-sensitive latches therefore never see D change while E is high.

## Interface
Parameters:
- WIDTH, 8, word width and D bus width (>= 2)
- SETUP_CYC, 1, cycles D is stable with E low before E rises (>= 1)
- ENABLE_CYC, 2, cycles E is held high (>= 1)
- HOLD_CYC, 1, cycles D is held stable after E falls (>= 1)

Ports:
- CLK  input  1  single clock; all state changes on the rising edge
- RST_N  input  1  asynchronous, active-low reset
- SIN  input  1  serial data bit, MSB first
- SIN_VALID  input  1  SIN is valid this cycle
- SIN_READY  output  1  block accepts a bit this cycle
- CLR  input  1  synchronous discard of a partial word
- D  output  WIDTH  parallel data to the latch bank (registered)
- E  output  1  latch enable to the latch bank (registered)
- BUSY  output  1  high in any state other than IDLE
- DONE  output  1  one-cycle pulse when a word has been fully latched

## Operation
- States: IDLE, SHIFT, SETUP, ENABLE, HOLD.
- Transfer: occurs on a rising edge where SIN_VALID && SIN_READY and RST_N is high.
- SIN_READY: high in IDLE and SHIFT only. It is decoded from state.
- Shift register: on each transfer, shift <= {shift[WIDTH-2:0], SIN}. The bit counter increments.
- IDLE: a transfer moves to SHIFT with count = 1.
- SHIFT: the transfer that makes count == WIDTH loads D <= {shift[WIDTH-2:0], SIN} on the same edge, clears the counter and moves to SETUP.
- SETUP: E = 0 for SETUP_CYC cycles, then move to ENABLE.
- ENABLE: E = 1 for ENABLE_CYC cycles, then move to HOLD.
- HOLD: E = 0 for HOLD_CYC cycles, then move to IDLE. DONE = 1 for exactly the first IDLE cycle.
- D retention: D changes only on the load edge and on reset. It holds its value indefinitely after DONE.
- CLR in SHIFT: clears the counter and shift register and returns to IDLE. CLR has priority over a simultaneous transfer, so that bit is dropped.
- CLR in IDLE, SETUP, ENABLE or HOLD: ignored. An enable pulse is never truncated.
- Phase counter: one counter of width $clog2(max(SETUP_CYC, ENABLE_CYC, HOLD_CYC)+1). It reloads on every phase entry.

## Timing
- Reset values: D = 0, E = 0, DONE = 0, BUSY = 0, state = IDLE, counters = 0.
- SIN_READY reads 1 during reset because the state is IDLE. No transfer is accepted while RST_N is low.
- Reset mid-operation: E drops to 0 and D to 0 asynchronously. Any partial word is lost.
- Last-bit edge t (the edge that loads D): D valid after t; E low for t..t+SETUP_CYC; E rises at t+SETUP_CYC.
- E falls at t+SETUP_CYC+ENABLE_CYC.
- Return to IDLE at t+SETUP_CYC+ENABLE_CYC+HOLD_CYC. DONE is high for the following cycle only.
- Minimum word period: WIDTH + SETUP_CYC + ENABLE_CYC + HOLD_CYC cycles.
- Back-to-back words: a bit may be accepted in the DONE cycle. That cycle is IDLE, so SIN_READY = 1.
- Gaps in SIN_VALID during SHIFT: the block waits indefinitely with count preserved. There is no timeout.

## Test plan
- Defaults, send 0xA5 MSB first, back-to-back: D = 0xA5 at the 8th-bit edge t; E high for exactly cycles t+1..t+2; DONE pulse once at t+4; a downstream latch model's Q == 0xA5.
- Send 0x3C with SIN_VALID low for 3 cycles between bits 4 and 5: count holds; D = 0x3C; E still high for exactly 2 cycles.
- After 3 bits of 0xFF, assert CLR together with SIN_VALID = 1, then send 0x3C: that bit is dropped; D = 0x3C; no stray E pulse before the final load.
- Hold SIN_VALID = 1 continuously across two words 0x81 then 0x7E: SIN_READY = 0 in SETUP/ENABLE/HOLD; D stays 0x81 throughout E high; D = 0x7E only at the second load edge.
- Drop RST_N mid-ENABLE: E = 0 and D = 0 immediately without waiting for a clock. After release, 0x55 loads cleanly; DONE pulses once.
- Parameters SETUP_CYC = 3, ENABLE_CYC = 1, HOLD_CYC = 2, WIDTH = 4, send 0x9: E rises at t+3 and falls at t+4; DONE at t+6; D = 0x9 unchanged from t through DONE.

Source files
------------

// File: rtl/serial_latch_loader.sv
// serial_latch_loader: assembles a serial MSB-first word, then drives D and the
// shared latch enable E with guaranteed setup, enable and hold windows.
module serial_latch_loader #(
    parameter int WIDTH      = 8,
    parameter int SETUP_CYC  = 1,
    parameter int ENABLE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             SIN,
    input  logic             SIN_VALID,
    output logic             SIN_READY,
    input  logic             CLR,
    output logic [WIDTH-1:0] D,
    output logic             E,
    output logic             BUSY,
    output logic             DONE
);
    localparam int MAX_A = SETUP_CYC > ENABLE_CYC ? SETUP_CYC : ENABLE_CYC;
    localparam int MAX_C = MAX_A > HOLD_CYC ? MAX_A : HOLD_CYC;
    localparam int PW    = $clog2(MAX_C + 1);
    localparam int CW    = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, SHIFT, SETUP, ENABLE, HOLD} state_t;

    state_t           state, state_next;
    logic [PW-1:0]    phase;
    logic [CW-1:0]    count;
    logic [WIDTH-2:0] shift;
    logic [WIDTH-1:0] word;
    logic             xfer, last, phase_end;

    assign word      = {shift, SIN};
    assign xfer      = SIN_VALID && SIN_READY;
    assign last      = count == CW'(WIDTH - 1);
    assign phase_end = phase == '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = xfer ? SHIFT : IDLE;
            SHIFT:   state_next = CLR ? IDLE : (xfer && last) ? SETUP : SHIFT;
            SETUP:   state_next = phase_end ? ENABLE : SETUP;
            ENABLE:  state_next = phase_end ? HOLD : ENABLE;
            HOLD:    state_next = phase_end ? IDLE : HOLD;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        SIN_READY = state == IDLE || state == SHIFT;
        BUSY      = state != IDLE;
    end

    // E and DONE come straight from flops so the latch bank never sees decode glitches
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            E    <= 1'b0;
            DONE <= 1'b0;
        end else begin
            E    <= state_next == ENABLE;
            DONE <= state == HOLD && phase_end;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase <= '0;
        end else if (state_next != state) begin
            phase <= state_next == SETUP  ? PW'(SETUP_CYC - 1)  :
                     state_next == ENABLE ? PW'(ENABLE_CYC - 1) :
                     state_next == HOLD   ? PW'(HOLD_CYC - 1)   : '0;
        end else if (!phase_end) begin
            phase <= phase - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shift <= '0;
            count <= '0;
            D     <= '0;
        end else if (state == SHIFT && CLR) begin
            shift <= '0;
            count <= '0;
        end else if (xfer) begin
            shift <= word[WIDTH-2:0];
            count <= (state == SHIFT && last) ? '0 : count + 1'b1;
            if (state == SHIFT && last) D <= word;
        end
    end
endmodule
